// File: rtl/gpio_exp_pkg.sv
// Shared definitions for the GPIO expander APB path: FSM encoding, default
// widths and the bank-select decode helper.
package gpio_exp_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_BERR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE,
    S_BERR   = ST_BERR
  } state_t;

  // One bit of the one-hot bank decode.
  function automatic logic bank_hit(input int unsigned bank, input int unsigned idx);
    return bank == idx;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the master not served last wins.
module apb_rr_arb2 (
  input  logic       sclk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic last;

  // last=1 out of reset so m0 wins the first tie
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn)     last <= 1'b1;
    else if (update) last <= owner;
  end

  assign gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/apb_bank_arbiter.sv
// Shares one APB bus to the GPIO banks between the SPI command path (m0) and
// the poll/interrupt engine (m1), with bank decode and a pready timeout.
module apb_bank_arbiter
  import gpio_exp_pkg::*;
#(
  parameter int NBANK      = 2,
  parameter int BANK_W     = 1,
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int TIMEOUT    = 15
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [BANK_W-1:0]     m0_bank,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [BANK_W-1:0]     m1_bank,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [NBANK-1:0]      psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [BANK_W:0]   NB      = (BANK_W + 1)'(NBANK);

  state_t                          state;
  logic                            cmd_vld;
  logic                            owner;
  logic                            wr_q;
  logic [BANK_W-1:0]               bank_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [DATA_WIDTH-1:0]           wdata_q;
  logic [CNT_W-1:0]                cnt;
  logic [1:0]                      req, arb_gnt, gnt_q, done_q, err_q;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q;
  logic [NBANK-1:0]                sel_dec;
  logic                            bank_ok;
  logic                            upd;

  assign req     = {m1_req, m0_req};
  assign upd     = (state == S_DONE) || (state == S_BERR);
  assign bank_ok = {1'b0, bank_q} < NB;

  for (genvar i = 0; i < NBANK; i++) begin : g_dec
    assign sel_dec[i] = bank_hit(32'(bank_q), i);
  end

  apb_rr_arb2 u_arb (
    .sclk   (sclk),
    .resetn (resetn),
    .req    (req),
    .update (upd),
    .owner  (owner),
    .gnt    (arb_gnt)
  );

  // Grant and latch happen in IDLE; the following IDLE cycle launches the
  // latched command, so SETUP is visible the cycle after the gnt pulse.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cmd_vld <= 1'b0;
      owner   <= 1'b0;
      wr_q    <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            cmd_vld <= 1'b0;
            if (bank_ok) begin
              state  <= S_SETUP;
              psel   <= sel_dec;
              pwrite <= wr_q;
              paddr  <= addr_q;
              pwdata <= wdata_q;
            end else begin
              state         <= S_BERR;
              done_q[owner] <= 1'b1;
              err_q[owner]  <= 1'b1;
            end
          end else if (|arb_gnt) begin
            cmd_vld <= 1'b1;
            owner   <= arb_gnt[1];
            gnt_q   <= arb_gnt;
            wr_q    <= arb_gnt[1] ? m1_write : m0_write;
            bank_q  <= arb_gnt[1] ? m1_bank  : m0_bank;
            addr_q  <= arb_gnt[1] ? m1_addr  : m0_addr;
            wdata_q <= arb_gnt[1] ? m1_wdata : m0_wdata;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
          cnt     <= '0;
        end
        S_ACCESS: begin
          if (pready || cnt == CNT_MAX) begin
            state         <= S_DONE;
            psel          <= '0;
            penable       <= 1'b0;
            done_q[owner] <= 1'b1;
            err_q[owner]  <= !pready;
            if (!wr_q) rdata_q[owner] <= pready ? prdata : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_BERR:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m0_gnt   = gnt_q[0];
  assign m1_gnt   = gnt_q[1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_apb_bank_arbiter.sv
// Directed bench for apb_bank_arbiter: writes, waited reads, tie alternation,
// timeout, bad bank and mid-transfer reset.
module tb_apb_bank_arbiter;

  logic       sclk = 1'b0;
  logic       resetn;
  logic       m0_req, m0_write, m1_req, m1_write;
  logic [1:0] m0_bank, m1_bank;
  logic [2:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [1:0] psel;
  logic       penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready;

  int nchk = 0;
  int nerr = 0;

  always #5 sclk = ~sclk;

  apb_bank_arbiter #(.NBANK(2), .BANK_W(2), .ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .sclk(sclk), .resetn(resetn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_bank(m0_bank), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_bank(m1_bank), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  // Bounded wait for any grant; g=0 on expiry.
  task automatic wait_gnt(output logic [1:0] g);
    int n = 0;
    g = 2'b00;
    while (g == 2'b00 && n < 20) begin
      tick(); n++;
      g = {m1_gnt, m0_gnt};
    end
  endtask

  // Bounded wait for any done; counts penable cycles seen on the way.
  task automatic wait_done(output logic [1:0] d, output int pen);
    int n = 0;
    d = 2'b00; pen = 0;
    while (d == 2'b00 && n < 40) begin
      tick(); n++;
      if (penable) pen++;
      d = {m1_done, m0_done};
    end
  endtask

  logic [1:0] g, d;
  int         pen, seen;

  initial begin
    resetn = 1'b0;
    m0_req = 0; m0_write = 0; m0_bank = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_write = 0; m1_bank = 0; m1_addr = 0; m1_wdata = 0;
    prdata = 0; pready = 0;

    // reset state
    tick();
    chk("rst psel", psel, 0);
    chk("rst penable", penable, 0);
    chk("rst gnt", {m1_gnt, m0_gnt}, 0);
    chk("rst done", {m1_done, m0_done}, 0);
    chk("rst rdata", {m1_rdata, m0_rdata}, 0);
    resetn = 1'b1;
    tick();

    // 1: m0 write bank1 addr5 A5, ready on first ACCESS cycle
    m0_req = 1; m0_write = 1; m0_bank = 1; m0_addr = 5; m0_wdata = 8'hA5; pready = 1;
    tick();
    chk("t1 m0_gnt", m0_gnt, 1);
    chk("t1 m1_gnt", m1_gnt, 0);
    chk("t1 psel at gnt", psel, 0);
    m0_req = 0;
    tick();
    chk("t1 setup psel", psel, 2'b10);
    chk("t1 setup penable", penable, 0);
    chk("t1 paddr", paddr, 5);
    chk("t1 pwdata", pwdata, 8'hA5);
    chk("t1 pwrite", pwrite, 1);
    tick();
    chk("t1 access penable", penable, 1);
    chk("t1 access done", m0_done, 0);
    tick();
    chk("t1 m0_done", m0_done, 1);
    chk("t1 m0_err", m0_err, 0);
    chk("t1 m1_done", m1_done, 0);
    chk("t1 done psel", psel, 0);
    chk("t1 done penable", penable, 0);
    chk("t1 paddr held", paddr, 5);
    pready = 0;
    tick();
    chk("t1 done pulse", m0_done, 0);

    // 2: m1 read bank0 addr2, ready after 3 wait cycles
    m1_req = 1; m1_write = 0; m1_bank = 0; m1_addr = 2; prdata = 8'h3C;
    tick();
    chk("t2 m1_gnt", m1_gnt, 1);
    m1_req = 0;
    tick();
    chk("t2 setup psel", psel, 2'b01);
    chk("t2 paddr", paddr, 2);
    chk("t2 pwrite", pwrite, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2 penable held", penable, 1);
      chk("t2 no early done", m1_done, 0);
    end
    pready = 1;
    tick();
    chk("t2 m1_done", m1_done, 1);
    chk("t2 m1_err", m1_err, 0);
    chk("t2 m1_rdata", m1_rdata, 8'h3C);
    chk("t2 m0 quiet", {m0_done, m0_rdata}, 0);
    chk("t2 psel off", psel, 0);
    prdata = 8'h00;
    tick();
    chk("t2 rdata held", m1_rdata, 8'h3C);

    // 3: simultaneous requests, three ties back-to-back
    m0_req = 1; m0_write = 1; m0_bank = 0; m0_addr = 1; m0_wdata = 8'h11;
    m1_req = 1; m1_write = 1; m1_bank = 1; m1_addr = 3; m1_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      chk("t3 winner", g, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (g[0]) m0_req = 0;
      if (g[1]) m1_req = 0;
      tick();
      chk("t3 setup psel", psel, (k % 2 == 0) ? 2'b01 : 2'b10);
      wait_done(d, pen);
      chk("t3 done owner", d, g);
      if (k < 2) begin
        if (g[0]) m0_req = 1;
        if (g[1]) m1_req = 1;
      end
    end
    chk("t3 write keeps m1_rdata", m1_rdata, 8'h3C);
    pready = 0;
    tick();

    // m0 read to load m0_rdata before the timeout case
    m0_req = 1; m0_write = 0; m0_bank = 1; m0_addr = 6; prdata = 8'h5A; pready = 1;
    wait_gnt(g);
    m0_req = 0;
    wait_done(d, pen);
    chk("t3b m0_rdata", m0_rdata, 8'h5A);
    pready = 0;
    tick();

    // 4: pready never comes
    m0_req = 1; m0_write = 0; m0_bank = 1; m0_addr = 7;
    wait_gnt(g);
    chk("t4 gnt", g, 2'b01);
    m0_req = 0;
    wait_done(d, pen);
    chk("t4 access cycles", pen, 15);
    chk("t4 done", d, 2'b01);
    chk("t4 err", m0_err, 1);
    chk("t4 rdata zeroed", m0_rdata, 0);
    chk("t4 psel off", psel, 0);
    tick();

    // 5: bank index out of range
    m1_req = 1; m1_write = 1; m1_bank = 2; m1_addr = 1;
    wait_gnt(g);
    chk("t5 gnt", g, 2'b10);
    m1_req = 0;
    seen = 0;
    tick();
    chk("t5 done", m1_done, 1);
    chk("t5 err", m1_err, 1);
    chk("t5 no psel", {psel, penable}, 0);
    chk("t5 m0 quiet", m0_done, 0);
    chk("t5 rdata kept", m1_rdata, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (psel != 0) seen = 1;
    end
    chk("t5 no apb later", seen, 0);
    m0_req = 1; m0_bank = 3;
    wait_gnt(g);
    m0_req = 0;
    tick();
    chk("t5 bank3 done+err", {m0_done, m0_err}, 2'b11);

    // 6: reset during ACCESS
    tick();
    m0_req = 1; m0_write = 1; m0_bank = 0; m0_addr = 4; m0_wdata = 8'h99; pready = 0;
    wait_gnt(g);
    m0_req = 0;
    tick();
    tick();
    chk("t6 in access", {psel, penable}, 3'b011);
    #2 resetn = 1'b0;
    #1;
    chk("t6 async psel", psel, 0);
    chk("t6 async penable", penable, 0);
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_done || m1_done || penable) seen = 1;
    end
    chk("t6 no done after reset", seen, 0);
    chk("t6 rdata reset", {m1_rdata, m0_rdata}, 0);
    m1_req = 1; m1_write = 0; m1_bank = 1; m1_addr = 3; prdata = 8'h77; pready = 1;
    wait_gnt(g);
    chk("t6 gnt", g, 2'b10);
    m1_req = 0;
    tick();
    tick();
    tick();
    chk("t6 done at gnt+3", {m1_done, m1_err}, 2'b10);
    chk("t6 rdata", m1_rdata, 8'h77);
    pready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
